// File: rtl/riscv_hazard_pkg.sv
// Shared encodings and scoreboard entry layout for the hazard unit.
// Entry fields are sized for the largest supported configuration; users zero-extend.
package riscv_hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int SB_RD_W  = 8;
   localparam int SB_CNT_W = 6;

   typedef struct packed {
      logic                valid;
      logic [SB_RD_W-1:0]  rd;
      logic [SB_CNT_W-1:0] cnt;
   } entry_t;

   // MEM beats WB; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic               wr_mem,
                                          input logic [SB_RD_W-1:0] rd_mem,
                                          input logic               wr_wb,
                                          input logic [SB_RD_W-1:0] rd_wb,
                                          input logic [SB_RD_W-1:0] rs);
      if (wr_mem && rd_mem != '0 && rd_mem == rs) return FWD_MEM;
      if (wr_wb && rd_wb != '0 && rd_wb == rs) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: stage operand info in, stall/forward/writeback controls out.
interface hazard_scoreboard_if #(
   parameter int NREG_W   = 5,
   parameter int NUM_LONG = 2,
   parameter int MAX_LAT  = 8
);
   localparam int LAT_W = $clog2(MAX_LAT + 1);
   localparam int IDX_W = (NUM_LONG > 1) ? $clog2(NUM_LONG) : 1;

   logic                 issue_ID;
   logic [NREG_W-1:0]    rs1n_ID, rs2n_ID, rdn_ID;
   logic                 use_rs1_ID, use_rs2_ID, RegWrite_ID;
   logic                 long_ID;
   logic [LAT_W-1:0]     lat_ID;
   logic [NREG_W-1:0]    rs1n_EX, rs2n_EX, rdn_EX;
   logic                 MemToReg_EX;
   logic                 RegWrite_MEM, RegWrite_WB;
   logic [NREG_W-1:0]    rdn_MEM, rdn_WB;
   logic                 BranchIsTaken_EX, Exception_WB;
   logic [1:0]           ForwardSrc1_EX, ForwardSrc2_EX;
   logic                 Stall_IF, Stall_ID, Flush_EX;
   logic                 long_wb_valid;
   logic [NREG_W-1:0]    long_wb_rdn;
   logic [IDX_W-1:0]     long_wb_idx;
   logic [2**NREG_W-1:0] busy_regs;

   modport master (
      output issue_ID, rs1n_ID, rs2n_ID, rdn_ID, use_rs1_ID, use_rs2_ID, RegWrite_ID,
             long_ID, lat_ID, rs1n_EX, rs2n_EX, rdn_EX, MemToReg_EX, RegWrite_MEM,
             RegWrite_WB, rdn_MEM, rdn_WB, BranchIsTaken_EX, Exception_WB,
      input  ForwardSrc1_EX, ForwardSrc2_EX, Stall_IF, Stall_ID, Flush_EX,
             long_wb_valid, long_wb_rdn, long_wb_idx, busy_regs
   );

   modport slave (
      input  issue_ID, rs1n_ID, rs2n_ID, rdn_ID, use_rs1_ID, use_rs2_ID, RegWrite_ID,
             long_ID, lat_ID, rs1n_EX, rs2n_EX, rdn_EX, MemToReg_EX, RegWrite_MEM,
             RegWrite_WB, rdn_MEM, rdn_WB, BranchIsTaken_EX, Exception_WB,
      output ForwardSrc1_EX, ForwardSrc2_EX, Stall_IF, Stall_ID, Flush_EX,
             long_wb_valid, long_wb_rdn, long_wb_idx, busy_regs
   );

endinterface

// File: rtl/hazard_sb_entry.sv
// One long-latency scoreboard slot: load, count down to 1, hold until granted, then free.
module hazard_sb_entry
   import riscv_hazard_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                load,
   input  logic                grant,
   input  logic [SB_RD_W-1:0]  load_rd,
   input  logic [SB_CNT_W-1:0] load_cnt,
   output entry_t              ent
);

   entry_t ent_q, ent_d;

   always_comb begin
      ent_d = ent_q;
      if (freeze) begin
         ent_d = ent_q;
      end else if (grant) begin
         ent_d = '0;
      end else if (load) begin
         ent_d.valid = 1'b1;
         ent_d.rd    = load_rd;
         ent_d.cnt   = load_cnt;
      end else if (ent_q.valid && ent_q.cnt > SB_CNT_W'(1)) begin
         ent_d.cnt = ent_q.cnt - SB_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ent_q <= '0;
      else      ent_q <= ent_d;
   end

   assign ent = ent_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: EX forwarding, load-use and long-op scoreboard stalls, and the
// single-port writeback arbiter for completed long ops.
module hazard_scoreboard
   import riscv_hazard_pkg::*;
#(
   parameter int NREG_W   = 5,
   parameter int NUM_LONG = 2,
   parameter int MAX_LAT  = 8
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave hz
);

   localparam int IDX_W = (NUM_LONG > 1) ? $clog2(NUM_LONG) : 1;
   localparam int NREGS = 2**NREG_W;

   entry_t [NUM_LONG-1:0] ents;
   logic   [NUM_LONG-1:0] free_v, load_v, grant_v;
   logic   [SB_RD_W-1:0]  rs1_id, rs2_id, rd_id;
   logic   [SB_CNT_W-1:0] lat_clamped;
   logic                  src1_used, src2_used, rd_writes;
   logic                  load_use, sb_raw, sb_waw, struct_full;
   logic                  hazard, accept, alloc, stall;
   logic                  free_found, grant_found;
   logic   [NREG_W-1:0]   grant_rd;
   logic   [IDX_W-1:0]    grant_idx;
   logic   [NREGS-1:0]    busy;

   assign rs1_id    = SB_RD_W'(hz.rs1n_ID);
   assign rs2_id    = SB_RD_W'(hz.rs2n_ID);
   assign rd_id     = SB_RD_W'(hz.rdn_ID);
   assign src1_used = hz.use_rs1_ID && hz.rs1n_ID != '0;
   assign src2_used = hz.use_rs2_ID && hz.rs2n_ID != '0;
   assign rd_writes = hz.RegWrite_ID && hz.rdn_ID != '0;

   assign load_use = hz.MemToReg_EX && hz.rdn_EX != '0 &&
                     ((hz.use_rs1_ID && hz.rs1n_ID == hz.rdn_EX) ||
                      (hz.use_rs2_ID && hz.rs2n_ID == hz.rdn_EX));

   always_comb begin
      lat_clamped = SB_CNT_W'(hz.lat_ID);
      if (hz.lat_ID == '0 || int'(hz.lat_ID) > MAX_LAT) lat_clamped = SB_CNT_W'(MAX_LAT);
   end

   // A granted entry stays valid until the edge, so it never shows up as free
   // in the cycle it writes back.
   always_comb begin
      sb_raw      = 1'b0;
      sb_waw      = 1'b0;
      struct_full = 1'b1;
      free_found  = 1'b0;
      grant_found = 1'b0;
      grant_rd    = '0;
      grant_idx   = '0;
      busy        = '0;
      free_v      = '0;
      grant_v     = '0;
      for (int i = 0; i < NUM_LONG; i++) begin
         if (ents[i].valid) begin
            if (src1_used && ents[i].rd == rs1_id) sb_raw = 1'b1;
            if (src2_used && ents[i].rd == rs2_id) sb_raw = 1'b1;
            if (rd_writes && ents[i].rd == rd_id)  sb_waw = 1'b1;
            busy[ents[i].rd[NREG_W-1:0]] = 1'b1;
            if (!grant_found && !hz.Exception_WB && ents[i].cnt == SB_CNT_W'(1)) begin
               grant_found = 1'b1;
               grant_v[i]  = 1'b1;
               grant_rd    = ents[i].rd[NREG_W-1:0];
               grant_idx   = IDX_W'(i);
            end
         end else begin
            struct_full = 1'b0;
            if (!free_found) begin
               free_found = 1'b1;
               free_v[i]  = 1'b1;
            end
         end
      end
      busy[0] = 1'b0;
   end

   assign hazard = load_use | sb_raw | sb_waw | (hz.long_ID & struct_full);
   assign accept = hz.issue_ID & ~hazard & ~hz.BranchIsTaken_EX & ~hz.Exception_WB;
   assign alloc  = accept & hz.long_ID & rd_writes;
   assign load_v = free_v & {NUM_LONG{alloc}};
   assign stall  = rst & hz.issue_ID & hazard;

   for (genvar g = 0; g < NUM_LONG; g++) begin : g_ent
      hazard_sb_entry u_ent (
         .clk      (clk),
         .rst      (rst),
         .freeze   (hz.Exception_WB),
         .load     (load_v[g]),
         .grant    (grant_v[g]),
         .load_rd  (rd_id),
         .load_cnt (lat_clamped),
         .ent      (ents[g])
      );
   end

   // Forward/stall paths are purely combinational, so gate them with reset;
   // the writeback port and bitmap are already zero from the cleared entries.
   assign hz.ForwardSrc1_EX = rst ? fwd_sel(hz.RegWrite_MEM, SB_RD_W'(hz.rdn_MEM), hz.RegWrite_WB,
                                            SB_RD_W'(hz.rdn_WB), SB_RD_W'(hz.rs1n_EX)) : FWD_RF;
   assign hz.ForwardSrc2_EX = rst ? fwd_sel(hz.RegWrite_MEM, SB_RD_W'(hz.rdn_MEM), hz.RegWrite_WB,
                                            SB_RD_W'(hz.rdn_WB), SB_RD_W'(hz.rs2n_EX)) : FWD_RF;
   assign hz.Stall_IF       = stall;
   assign hz.Stall_ID       = stall;
   assign hz.Flush_EX       = stall;
   assign hz.long_wb_valid  = grant_found;
   assign hz.long_wb_rdn    = grant_rd;
   assign hz.long_wb_idx    = grant_idx;
   assign hz.busy_regs      = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus queues expected snapshots and writebacks, a negedge monitor checks them.
module tb_hazard_scoreboard;

   typedef struct {
      int          cyc;
      string       name;
      logic [39:0] v;
   } snap_t;

   typedef struct {
      int         cyc;
      logic [4:0] rdn;
      logic       idx;
   } wb_t;

   logic  clk, rst;
   int    cyc = 0;
   bit    done = 0;
   int    checks = 0;
   int    errors = 0;
   snap_t snap_q[$];
   wb_t   wb_q[$];
   snap_t s;
   wb_t   w;
   logic [39:0] act;

   hazard_scoreboard_if hz ();

   hazard_scoreboard dut (.clk(clk), .rst(rst), .hz(hz));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.issue_ID = 0; hz.rs1n_ID = 0; hz.rs2n_ID = 0; hz.rdn_ID = 0;
      hz.use_rs1_ID = 0; hz.use_rs2_ID = 0; hz.RegWrite_ID = 0; hz.long_ID = 0; hz.lat_ID = 0;
      hz.rs1n_EX = 0; hz.rs2n_EX = 0; hz.rdn_EX = 0; hz.MemToReg_EX = 0;
      hz.RegWrite_MEM = 0; hz.RegWrite_WB = 0; hz.rdn_MEM = 0; hz.rdn_WB = 0;
      hz.BranchIsTaken_EX = 0; hz.Exception_WB = 0;
   endtask

   task automatic issue_long(input logic [4:0] rd, input logic [3:0] lat);
      hz.issue_ID = 1; hz.long_ID = 1; hz.RegWrite_ID = 1; hz.rdn_ID = rd; hz.lat_ID = lat;
   endtask

   // Inputs that would forward and stall if the unit were out of reset.
   task automatic hot_inputs();
      hz.RegWrite_MEM = 1; hz.rdn_MEM = 5; hz.rs1n_EX = 5; hz.rs2n_EX = 5;
      hz.MemToReg_EX = 1; hz.rdn_EX = 7; hz.use_rs2_ID = 1; hz.rs2n_ID = 7;
      issue_long(5'd9, 4'd1);
   endtask

   task automatic expect_out(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                             input logic st, input logic wbv, input logic [31:0] busy);
      snap_q.push_back('{cyc, nm, {f1, f2, st, st, st, wbv, busy}});
   endtask

   task automatic expect_wb(input int dly, input logic [4:0] rdn, input logic idx);
      wb_q.push_back('{cyc + dly, rdn, idx});
   endtask

   initial forever begin
      @(negedge clk);
      act = {hz.ForwardSrc1_EX, hz.ForwardSrc2_EX, hz.Stall_IF, hz.Stall_ID, hz.Flush_EX,
             hz.long_wb_valid, hz.busy_regs};
      if (hz.long_wb_valid) begin
         checks++;
         if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected cyc=%0d got rdn=%0d idx=%0d", cyc, hz.long_wb_rdn, hz.long_wb_idx);
         end else begin
            w = wb_q.pop_front();
            if (w.cyc != cyc || w.rdn != hz.long_wb_rdn || w.idx != hz.long_wb_idx) begin
               errors++;
               $display("FAIL wb_rd%0d got cyc=%0d rdn=%0d idx=%0d want cyc=%0d rdn=%0d idx=%0d",
                        w.rdn, cyc, hz.long_wb_rdn, hz.long_wb_idx, w.cyc, w.rdn, w.idx);
            end
         end
      end
      while (wb_q.size() != 0 && wb_q[0].cyc < cyc) begin
         w = wb_q.pop_front();
         checks++;
         errors++;
         $display("FAIL wb_missing rdn=%0d want cyc=%0d got none by cyc=%0d", w.rdn, w.cyc, cyc);
      end
      while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
         s = snap_q.pop_front();
         checks++;
         if (s.cyc != cyc || act != s.v) begin
            errors++;
            $display("FAIL %s cyc=%0d got f1f2/st3/wbv/busy=%h want %h (due cyc %0d)",
                     s.name, cyc, act, s.v, s.cyc);
         end
      end
      if (done) begin
         checks++;
         if (wb_q.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got wb=%0d snap=%0d want 0 0", wb_q.size(), snap_q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      rst = 0;
      idle();
      hot_inputs();
      step(); expect_out("rst_low", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); expect_out("rst_low_edge", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); rst = 1; idle(); expect_out("rst_release", 2'b00, 2'b00, 0, 0, 32'h0);

      // forwarding priority
      step(); hz.RegWrite_MEM = 1; hz.rdn_MEM = 5; hz.RegWrite_WB = 1; hz.rdn_WB = 5;
      hz.rs1n_EX = 5; hz.rs2n_EX = 5;
      expect_out("fwd_mem_wins", 2'b10, 2'b10, 0, 0, 32'h0);
      step(); hz.rdn_MEM = 0; expect_out("fwd_wb", 2'b01, 2'b01, 0, 0, 32'h0);
      step(); hz.rdn_MEM = 5; hz.rs2n_EX = 9; hz.rdn_WB = 9;
      expect_out("fwd_mix", 2'b10, 2'b01, 0, 0, 32'h0);
      step(); hz.RegWrite_MEM = 0; expect_out("fwd_mem_nowrite", 2'b00, 2'b01, 0, 0, 32'h0);
      step(); idle(); hz.RegWrite_WB = 1; expect_out("fwd_x0", 2'b00, 2'b00, 0, 0, 32'h0);

      // load-use
      step(); idle(); hz.MemToReg_EX = 1; hz.rdn_EX = 7; hz.issue_ID = 1; hz.use_rs2_ID = 1; hz.rs2n_ID = 7;
      expect_out("load_use", 2'b00, 2'b00, 1, 0, 32'h0);
      step(); hz.MemToReg_EX = 0; expect_out("load_use_clear", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); hz.MemToReg_EX = 1; hz.use_rs2_ID = 0; expect_out("load_use_unused", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); hz.use_rs1_ID = 1; hz.rs1n_ID = 7; hz.issue_ID = 0;
      expect_out("load_use_noissue", 2'b00, 2'b00, 0, 0, 32'h0);

      // single long op, RAW and WAW against it
      step(); idle(); issue_long(5'd3, 4'd4); expect_out("long_issue", 2'b00, 2'b00, 0, 0, 32'h0);
      expect_wb(4, 5'd3, 1'b0);
      step(); idle(); expect_out("long_busy", 2'b00, 2'b00, 0, 0, 32'h8);
      step(); hz.issue_ID = 1; hz.use_rs1_ID = 1; hz.rs1n_ID = 3;
      expect_out("sb_raw", 2'b00, 2'b00, 1, 0, 32'h8);
      step(); idle(); hz.issue_ID = 1; hz.RegWrite_ID = 1; hz.rdn_ID = 3;
      expect_out("sb_waw", 2'b00, 2'b00, 1, 0, 32'h8);
      step(); idle(); expect_out("long_wb", 2'b00, 2'b00, 0, 1, 32'h8);
      step(); expect_out("long_clear", 2'b00, 2'b00, 0, 0, 32'h0);

      // clamp lat>MAX_LAT to 8 and freeze 3 cycles mid-countdown
      step(); issue_long(5'd4, 4'd9); expect_out("clamp_issue", 2'b00, 2'b00, 0, 0, 32'h0);
      expect_wb(11, 5'd4, 1'b0);
      step(); idle(); expect_out("clamp_busy", 2'b00, 2'b00, 0, 0, 32'h10);
      step(); hz.Exception_WB = 1; issue_long(5'd6, 4'd1);
      expect_out("exc_no_issue", 2'b00, 2'b00, 0, 0, 32'h10);
      step(); expect_out("exc_hold", 2'b00, 2'b00, 0, 0, 32'h10);
      step(); expect_out("exc_hold2", 2'b00, 2'b00, 0, 0, 32'h10);
      step(); idle(); expect_out("exc_release", 2'b00, 2'b00, 0, 0, 32'h10);
      repeat (6) step();
      expect_out("clamp_wb", 2'b00, 2'b00, 0, 1, 32'h10);
      step(); expect_out("clamp_clear", 2'b00, 2'b00, 0, 0, 32'h0);

      // freeze while an entry is ready
      step(); issue_long(5'd5, 4'd1); expect_out("rdy_issue", 2'b00, 2'b00, 0, 0, 32'h0);
      expect_wb(3, 5'd5, 1'b0);
      step(); idle(); hz.Exception_WB = 1; expect_out("rdy_frozen", 2'b00, 2'b00, 0, 0, 32'h20);
      step(); expect_out("rdy_frozen2", 2'b00, 2'b00, 0, 0, 32'h20);
      step(); idle(); expect_out("rdy_wb", 2'b00, 2'b00, 0, 1, 32'h20);
      step(); expect_out("rdy_clear", 2'b00, 2'b00, 0, 0, 32'h0);

      // two entries ready together, third issue waits for a free slot
      step(); issue_long(5'd10, 4'd2); expect_out("dual_a", 2'b00, 2'b00, 0, 0, 32'h0);
      expect_wb(2, 5'd10, 1'b0);
      step(); issue_long(5'd11, 4'd1); expect_out("dual_b", 2'b00, 2'b00, 0, 0, 32'h400);
      expect_wb(2, 5'd11, 1'b1);
      step(); issue_long(5'd12, 4'd1); expect_out("dual_full", 2'b00, 2'b00, 1, 1, 32'hC00);
      step(); expect_out("dual_reuse", 2'b00, 2'b00, 0, 1, 32'h800);
      expect_wb(1, 5'd12, 1'b0);
      step(); idle(); expect_out("dual_c", 2'b00, 2'b00, 0, 1, 32'h1000);
      step(); expect_out("dual_done", 2'b00, 2'b00, 0, 0, 32'h0);

      // rd=0 long op allocates nothing
      step(); issue_long(5'd0, 4'd2); expect_out("rd0_issue", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); idle(); expect_out("rd0_busy", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); step(); expect_out("rd0_nowb", 2'b00, 2'b00, 0, 0, 32'h0);

      // lat 0 clamps to 8; a branch keeps the older entry and blocks the new issue
      step(); issue_long(5'd13, 4'd0); expect_out("br_issue", 2'b00, 2'b00, 0, 0, 32'h0);
      expect_wb(8, 5'd13, 1'b0);
      step(); idle(); hz.BranchIsTaken_EX = 1; issue_long(5'd14, 4'd1);
      expect_out("br_redirect", 2'b00, 2'b00, 0, 0, 32'h2000);
      step(); idle(); expect_out("br_kept", 2'b00, 2'b00, 0, 0, 32'h2000);
      repeat (6) step();
      expect_out("lat0_wb", 2'b00, 2'b00, 0, 1, 32'h2000);
      step(); expect_out("lat0_clear", 2'b00, 2'b00, 0, 0, 32'h0);

      // asynchronous reset with two live entries
      step(); issue_long(5'd20, 4'd8);
      step(); issue_long(5'd21, 4'd8);
      step(); idle(); expect_out("pre_rst", 2'b00, 2'b00, 0, 0, 32'h300000);
      step(); rst = 0; hot_inputs(); expect_out("rst_async", 2'b00, 2'b00, 0, 0, 32'h0);
      step(); rst = 1; idle(); expect_out("rst_resume", 2'b00, 2'b00, 0, 0, 32'h0);
      repeat (10) step();
      expect_out("rst_no_pending", 2'b00, 2'b00, 0, 0, 32'h0);

      done = 1;
      repeat (4) @(posedge clk);
      $display("FAIL no_summary cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
